uart_hex_formatter: RTL and testbench

UART_HEX_FORMATTER -- requirements
Module: uart_hex_formatter

---
 rtl/uart_hex_formatter.sv | 166 ++++++++++++++++
 tb/tb_uart_hex_formatter.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_hex_formatter.sv
// Prints 32-bit words as 8 ASCII hex digits followed by CR LF, one byte per
// handshake, with a small word FIFO in front of the serializer.
module uart_hex_formatter #(
    parameter int DEPTH     = 4,
    parameter bit UPPERCASE = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] word_in,
    input  logic        word_in_valid,
    output logic        word_in_ready,
    output logic [7:0]  data_out,
    output logic        data_out_valid,
    input  logic        data_out_ready
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DIGIT = 2'd1,
        CR    = 2'd2,
        LF    = 2'd3
    } state_t;

    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [AW:0]   count_reg;
    logic          fifo_empty;
    logic          push;
    logic          pop;
    logic [31:0]   head;

    state_t      state_reg;
    state_t      state_next;
    logic [31:0] shift_reg;
    logic [31:0] shift_next;
    logic [2:0]  nib_reg;
    logic [2:0]  nib_next;
    logic [7:0]  data_reg;
    logic [7:0]  data_next;
    logic        valid_reg;
    logic        handshake;

    logic [7:0]  hex_lut [16];

    // Nibble-to-ASCII table, built once at elaboration.
    genvar gi;
    for (gi = 0; gi < 16; gi++) begin : g_hex
        if (gi < 10) begin : g_num
            assign hex_lut[gi] = 8'h30 + 8'(gi);
        end else begin : g_alpha
            assign hex_lut[gi] = (UPPERCASE ? 8'h41 : 8'h61) + 8'(gi - 10);
        end
    end

    // Ready reflects only the current occupancy, so a full FIFO refuses a
    // push even in a cycle where the serializer pops.
    assign word_in_ready = (count_reg != (AW+1)'(DEPTH));
    assign fifo_empty    = (count_reg == '0);
    assign push          = word_in_valid && word_in_ready;
    assign head          = mem[rd_ptr_reg];
    assign handshake     = valid_reg && data_out_ready;

    assign data_out       = data_reg;
    assign data_out_valid = valid_reg;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= word_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    always_comb begin
        state_next = state_reg;
        shift_next = shift_reg;
        nib_next   = nib_reg;
        data_next  = data_reg;
        pop        = 1'b0;
        case (state_reg)
            IDLE: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    state_next = DIGIT;
                    nib_next   = 3'd0;
                    data_next  = hex_lut[head[31:28]];
                    shift_next = {head[27:0], 4'h0};
                end
            end
            DIGIT: begin
                if (handshake) begin
                    if (nib_reg == 3'd7) begin
                        state_next = CR;
                        data_next  = 8'h0D;
                    end else begin
                        nib_next   = nib_reg + 3'd1;
                        data_next  = hex_lut[shift_reg[31:28]];
                        shift_next = {shift_reg[27:0], 4'h0};
                    end
                end
            end
            CR: begin
                if (handshake) begin
                    state_next = LF;
                    data_next  = 8'h0A;
                end
            end
            LF: begin
                if (handshake) begin
                    // Chain straight into the next line when a word is waiting.
                    if (!fifo_empty) begin
                        pop        = 1'b1;
                        state_next = DIGIT;
                        nib_next   = 3'd0;
                        data_next  = hex_lut[head[31:28]];
                        shift_next = {head[27:0], 4'h0};
                    end else begin
                        state_next = IDLE;
                        data_next  = 8'h00;
                    end
                end
            end
            default: begin
                state_next = IDLE;
                data_next  = 8'h00;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            shift_reg <= '0;
            nib_reg   <= '0;
            data_reg  <= 8'h00;
            valid_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            shift_reg <= shift_next;
            nib_reg   <= nib_next;
            data_reg  <= data_next;
            valid_reg <= (state_next != IDLE);
        end
    end

endmodule

// File: tb/tb_uart_hex_formatter.sv
// Scoreboard bench for uart_hex_formatter: expected bytes are queued when a
// word is accepted and compared as the transmitter side consumes them.
module tb_uart_hex_formatter;
    localparam int TB_DEPTH = 4;

    logic        clk;
    logic        rst;
    logic [31:0] word_in;
    logic        word_in_valid;
    logic        word_in_ready;
    logic [7:0]  data_out;
    logic        data_out_valid;
    logic        data_out_ready;

    logic [31:0] lc_word_in;
    logic        lc_word_in_valid;
    logic        lc_word_in_ready;
    logic [7:0]  lc_data_out;
    logic        lc_data_out_valid;
    logic        lc_data_out_ready;

    int pass_cnt  = 0;
    int total_cnt = 0;
    logic [7:0] exp_q [$];

    uart_hex_formatter #(.DEPTH(TB_DEPTH), .UPPERCASE(1'b1)) dut (
        .clk(clk), .rst(rst),
        .word_in(word_in), .word_in_valid(word_in_valid), .word_in_ready(word_in_ready),
        .data_out(data_out), .data_out_valid(data_out_valid), .data_out_ready(data_out_ready)
    );

    uart_hex_formatter #(.DEPTH(TB_DEPTH), .UPPERCASE(1'b0)) dut_lc (
        .clk(clk), .rst(rst),
        .word_in(lc_word_in), .word_in_valid(lc_word_in_valid), .word_in_ready(lc_word_in_ready),
        .data_out(lc_data_out), .data_out_valid(lc_data_out_valid), .data_out_ready(lc_data_out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: expected ASCII line for one word.
    function automatic void push_line(input logic [31:0] w, input bit upper);
        logic [3:0] n;
        for (int i = 7; i >= 0; i--) begin
            n = w[i*4 +: 4];
            if (n < 4'd10) exp_q.push_back(8'h30 + 8'(n));
            else exp_q.push_back((upper ? 8'h37 : 8'h57) + 8'(n));
        end
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        word_in = '0; word_in_valid = 1'b0; data_out_ready = 1'b0;
        lc_word_in = '0; lc_word_in_valid = 1'b0; lc_data_out_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        total_cnt++;
        if (data_out_valid !== 1'b0) $display("FAIL reset_valid: got %b, expected 0", data_out_valid);
        else pass_cnt++;
        total_cnt++;
        if (data_out !== 8'h00) $display("FAIL reset_data: got %02h, expected 00", data_out);
        else pass_cnt++;
        total_cnt++;
        if (word_in_ready !== 1'b1) $display("FAIL reset_ready: got %b, expected 1", word_in_ready);
        else pass_cnt++;
        total_cnt++;
        if (lc_data_out_valid !== 1'b0) $display("FAIL reset_lc_valid: got %b, expected 0", lc_data_out_valid);
        else pass_cnt++;
        $display("reset: done");
    endtask

    task automatic test_single();
        int first, last, got;
        logic [7:0] exp;
        exp_q.delete();
        data_out_ready = 1'b1;
        word_in = 32'hDEADBEEF; word_in_valid = 1'b1;
        total_cnt++;
        if (word_in_ready !== 1'b1) $display("FAIL single_accept: got %b, expected 1", word_in_ready);
        else pass_cnt++;
        push_line(32'hDEADBEEF, 1'b1);
        @(negedge clk);
        word_in_valid = 1'b0;
        first = -1; last = -1; got = 0;
        for (int cyc = 1; cyc <= 30 && got < 10; cyc++) begin
            if (data_out_valid === 1'b1) begin
                exp = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
                total_cnt++;
                if (data_out !== exp) $display("FAIL single_byte%0d: got %02h, expected %02h", got, data_out, exp);
                else pass_cnt++;
                if (first < 0) first = cyc;
                last = cyc;
                got++;
            end
            @(negedge clk);
        end
        total_cnt++;
        if (got != 10) $display("FAIL single_count: got %0d, expected 10", got);
        else pass_cnt++;
        total_cnt++;
        if (first != 2) $display("FAIL single_latency: got %0d, expected 2", first);
        else pass_cnt++;
        total_cnt++;
        if (last - first != 9) $display("FAIL single_contiguous: got span %0d, expected 9", last - first);
        else pass_cnt++;
        total_cnt++;
        if (data_out_valid !== 1'b0) $display("FAIL single_idle: got %b, expected 0", data_out_valid);
        else pass_cnt++;
        $display("single: DEADBEEF line, %0d bytes, first at cycle %0d", got, first);
    endtask

    task automatic test_stall();
        int got;
        bit held;
        logic [7:0] held_data, exp;
        exp_q.delete();
        data_out_ready = 1'b0;
        word_in = 32'hDEADBEEF; word_in_valid = 1'b1;
        push_line(32'hDEADBEEF, 1'b1);
        @(negedge clk);
        word_in_valid = 1'b0;
        got = 0; held = 1'b0; held_data = 8'h00;
        for (int cyc = 1; cyc <= 80 && got < 10; cyc++) begin
            if (held) begin
                total_cnt++;
                if (data_out_valid !== 1'b1 || data_out !== held_data)
                    $display("FAIL stall_hold: got %b/%02h, expected 1/%02h", data_out_valid, data_out, held_data);
                else pass_cnt++;
            end
            data_out_ready = (cyc % 4 == 0);
            held = 1'b0;
            if (data_out_valid === 1'b1) begin
                if (data_out_ready) begin
                    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
                    total_cnt++;
                    if (data_out !== exp) $display("FAIL stall_byte%0d: got %02h, expected %02h", got, data_out, exp);
                    else pass_cnt++;
                    got++;
                end else begin
                    held = 1'b1;
                    held_data = data_out;
                end
            end
            @(negedge clk);
        end
        data_out_ready = 1'b0;
        total_cnt++;
        if (got != 10) $display("FAIL stall_count: got %0d, expected 10", got);
        else pass_cnt++;
        total_cnt++;
        if (data_out_valid !== 1'b0) $display("FAIL stall_idle: got %b, expected 0", data_out_valid);
        else pass_cnt++;
        $display("stall: %0d bytes with ready 1-in-4", got);
    endtask

    task automatic test_full();
        int n, got;
        logic [7:0] exp;
        exp_q.delete();
        data_out_ready = 1'b0;
        n = 0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            word_in = 32'h5AC0FFEE ^ {n[7:0], 24'h0};
            word_in_valid = 1'b1;
            if (word_in_ready === 1'b1) begin
                push_line(word_in, 1'b1);
                n++;
            end
            @(negedge clk);
        end
        total_cnt++;
        if (n != TB_DEPTH + 1) $display("FAIL full_accepted: got %0d, expected %0d", n, TB_DEPTH + 1);
        else pass_cnt++;
        total_cnt++;
        if (word_in_ready !== 1'b0) $display("FAIL full_ready: got %b, expected 0", word_in_ready);
        else pass_cnt++;
        total_cnt++;
        if (data_out_valid !== 1'b1) $display("FAIL full_waiting: got %b, expected 1", data_out_valid);
        else pass_cnt++;
        word_in_valid = 1'b0;
        data_out_ready = 1'b1;
        got = 0;
        for (int cyc = 0; cyc < 200 && exp_q.size() > 0; cyc++) begin
            if (data_out_valid === 1'b1) begin
                exp = exp_q.pop_front();
                total_cnt++;
                if (data_out !== exp) $display("FAIL full_byte%0d: got %02h, expected %02h", got, data_out, exp);
                else pass_cnt++;
                got++;
            end
            @(negedge clk);
        end
        total_cnt++;
        if (exp_q.size() != 0) $display("FAIL full_drain: got %0d bytes left, expected 0", exp_q.size());
        else pass_cnt++;
        total_cnt++;
        if (data_out_valid !== 1'b0) $display("FAIL full_idle: got %b, expected 0", data_out_valid);
        else pass_cnt++;
        $display("full: %0d words accepted, %0d bytes drained", n, got);
    endtask

    task automatic test_back_to_back();
        int first, last, got;
        logic [7:0] exp;
        exp_q.delete();
        data_out_ready = 1'b1;
        word_in = 32'h01234567; word_in_valid = 1'b1;
        push_line(32'h01234567, 1'b1);
        @(negedge clk);
        word_in = 32'h89ABCDEF;
        total_cnt++;
        if (word_in_ready !== 1'b1) $display("FAIL b2b_accept: got %b, expected 1", word_in_ready);
        else pass_cnt++;
        push_line(32'h89ABCDEF, 1'b1);
        @(negedge clk);
        word_in_valid = 1'b0;
        first = -1; last = -1; got = 0;
        for (int cyc = 2; cyc <= 60 && got < 20; cyc++) begin
            if (data_out_valid === 1'b1) begin
                exp = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
                total_cnt++;
                if (data_out !== exp) $display("FAIL b2b_byte%0d: got %02h, expected %02h", got, data_out, exp);
                else pass_cnt++;
                if (first < 0) first = cyc;
                last = cyc;
                got++;
            end
            @(negedge clk);
        end
        total_cnt++;
        if (got != 20 || last - first != 19)
            $display("FAIL b2b_contiguous: got %0d bytes over span %0d, expected 20 over 19", got, last - first);
        else pass_cnt++;
        total_cnt++;
        if (data_out_valid !== 1'b0) $display("FAIL b2b_idle: got %b, expected 0", data_out_valid);
        else pass_cnt++;
        $display("back_to_back: %0d bytes, first at cycle %0d", got, first);
    endtask

    task automatic test_lowercase();
        int got;
        logic [7:0] exp;
        exp_q.delete();
        lc_data_out_ready = 1'b1;
        lc_word_in = 32'h0000ABCF; lc_word_in_valid = 1'b1;
        total_cnt++;
        if (lc_word_in_ready !== 1'b1) $display("FAIL lc_accept: got %b, expected 1", lc_word_in_ready);
        else pass_cnt++;
        push_line(32'h0000ABCF, 1'b0);
        @(negedge clk);
        lc_word_in_valid = 1'b0;
        got = 0;
        for (int cyc = 1; cyc <= 30 && got < 10; cyc++) begin
            if (lc_data_out_valid === 1'b1) begin
                exp = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
                total_cnt++;
                if (lc_data_out !== exp) $display("FAIL lc_byte%0d: got %02h, expected %02h", got, lc_data_out, exp);
                else pass_cnt++;
                got++;
            end
            @(negedge clk);
        end
        total_cnt++;
        if (got != 10) $display("FAIL lc_count: got %0d, expected 10", got);
        else pass_cnt++;
        $display("lowercase: 0000ABCF line, %0d bytes", got);
    endtask

    task automatic test_mid_reset();
        int first, got;
        logic [7:0] exp;
        exp_q.delete();
        data_out_ready = 1'b1;
        word_in = 32'h13579BDF; word_in_valid = 1'b1;
        push_line(32'h13579BDF, 1'b1);
        @(negedge clk);
        word_in = 32'h2468ACE0;
        @(negedge clk);
        word_in = 32'h0F0F0F0F;
        for (int k = 0; k < 3; k++) begin
            exp = exp_q.pop_front();
            total_cnt++;
            if (data_out_valid !== 1'b1 || data_out !== exp)
                $display("FAIL rst_pre_byte%0d: got %b/%02h, expected 1/%02h", k, data_out_valid, data_out, exp);
            else pass_cnt++;
            @(negedge clk);
            word_in_valid = 1'b0;
        end
        rst = 1'b1;
        word_in = 32'hBAD0BAD0; word_in_valid = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        word_in_valid = 1'b0;
        total_cnt++;
        if (data_out_valid !== 1'b0) $display("FAIL rst_valid: got %b, expected 0", data_out_valid);
        else pass_cnt++;
        total_cnt++;
        if (word_in_ready !== 1'b1) $display("FAIL rst_ready: got %b, expected 1", word_in_ready);
        else pass_cnt++;
        exp_q.delete();
        word_in = 32'h00000001; word_in_valid = 1'b1;
        push_line(32'h00000001, 1'b1);
        @(negedge clk);
        word_in_valid = 1'b0;
        first = -1; got = 0;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            if (data_out_valid === 1'b1) begin
                exp = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
                total_cnt++;
                if (data_out !== exp) $display("FAIL rst_fresh_byte%0d: got %02h, expected %02h", got, data_out, exp);
                else pass_cnt++;
                if (first < 0) first = cyc;
                got++;
            end
            @(negedge clk);
        end
        total_cnt++;
        if (got != 10 || first != 2) $display("FAIL rst_fresh_line: got %0d bytes from cycle %0d, expected 10 from 2", got, first);
        else pass_cnt++;
        $display("mid_reset: fresh line %0d bytes", got);
    endtask

    initial begin
        test_reset();
        test_single();
        test_stall();
        test_full();
        test_back_to_back();
        test_lowercase();
        test_mid_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
